// File: rtl/twiddle_pkg.sv
// twiddle_pkg: shared definitions for the twiddle sequencer slice.
//   state_t    - sequencer FSM encoding (IDLE / SIN / COS / VALID)
//   QUARTER    - quarter-turn phase offset turning a sine lookup into cosine
//   PHASE_FULL - phase steps per full circle of the LUT wrapper
//   sat_neg()  - two's-complement negate that saturates the most negative code
package twiddle_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SIN   = 2'd1,
      ST_COS   = 2'd2,
      ST_VALID = 2'd3
   } state_t;

   localparam int QUARTER    = 64;
   localparam int PHASE_FULL = 256;

   // Negate a w-bit signed value carried in 32 bits. The most negative
   // w-bit code has no positive counterpart, so it maps to the maximum.
   function automatic logic signed [31:0] sat_neg(input logic signed [31:0] x,
                                                  input int w);
      logic signed [31:0] mx;
      mx = (32'sd1 <<< (w - 1)) - 32'sd1;
      if (x < -mx) return mx;
      return -x;
   endfunction

endpackage

// File: rtl/twiddle_addr_gen.sv
// twiddle_addr_gen: DIF twiddle index generator.
//   Holds the latched (clamped) stage, the inner counter k and outer counter
//   g. phase = k << (s + PHASE_W - LOG2N), i.e. k * step mod PHASE_FULL.
// Ports:
//   clk, rst_n  clock / async active-low reset
//   load        latch stage (clamped to LOG2N-1) and clear k/g
//   adv         step k; on k wrap step g
//   clr         clear everything (abort); wins over load/adv
//   stage       requested DIF stage
//   phase       current twiddle phase
//   last        k and g both at their final values
module twiddle_addr_gen
   import twiddle_pkg::*;
#(
   parameter int LOG2N   = 8,
   parameter int PHASE_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load,
   input  logic               adv,
   input  logic               clr,
   input  logic [2:0]         stage,
   output logic [PHASE_W-1:0] phase,
   output logic               last
);

   // k spans N/2 values at most and g likewise, so LOG2N bits cover both.
   localparam int CW = LOG2N;

   logic [2:0]    s_r, s_cl;
   logic [CW-1:0] k_r, g_r, kmax, gmax;
   logic          k_wrap;

   always_comb begin
      s_cl   = (int'(stage) >= LOG2N) ? 3'(LOG2N - 1) : stage;
      // 32-bit arithmetic: s+1 reaches 8 and would overflow the 3-bit stage.
      kmax   = CW'(((32'd1 << LOG2N) >> (32'(s_r) + 32'd1)) - 32'd1);
      gmax   = CW'((32'd1 << s_r) - 32'd1);
      k_wrap = (k_r == kmax);
      last   = k_wrap && (g_r == gmax);
      phase  = PHASE_W'(32'(k_r) << (32'(s_r) + 32'(PHASE_W - LOG2N)));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_r <= '0;
         k_r <= '0;
         g_r <= '0;
      end else if (clr) begin
         s_r <= '0;
         k_r <= '0;
         g_r <= '0;
      end else if (load) begin
         s_r <= s_cl;
         k_r <= '0;
         g_r <= '0;
      end else if (adv) begin
         if (k_wrap) begin
            k_r <= '0;
            g_r <= g_r + CW'(1);
         end else begin
            k_r <= k_r + CW'(1);
         end
      end
   end

endmodule

// File: rtl/twiddle_seq.sv
// twiddle_seq: per-frame DIF twiddle sequencer for one butterfly stage.
//   Time-shares one combinational sine LUT: SIN looks up phase, COS looks up
//   phase+QUARTER, then VALID offers W = cos - j*sin to the BFU.
// Ports:
//   clk, rst_n   clock / async active-low reset
//   start,stage  frame start (IDLE only) and DIF stage index
//   flush        synchronous abort to IDLE, no done pulse
//   lut_phi      phase to the LUT wrapper; lut_data its signed result
//   tw_valid/tw_ready/tw_re/tw_im/tw_last  twiddle output handshake
//   busy         not IDLE
//   done         one-cycle pulse after the final handshake
module twiddle_seq
   import twiddle_pkg::*;
#(
   parameter int LOG2N   = 8,
   parameter int PHASE_W = 8,
   parameter int DATA_W  = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [2:0]         stage,
   input  logic               flush,
   output logic [PHASE_W-1:0] lut_phi,
   input  logic [DATA_W-1:0]  lut_data,
   output logic               tw_valid,
   input  logic               tw_ready,
   output logic [DATA_W-1:0]  tw_re,
   output logic [DATA_W-1:0]  tw_im,
   output logic               tw_last,
   output logic               busy,
   output logic               done
);

   state_t                    state, nstate;
   logic                      load, adv;
   logic [PHASE_W-1:0]        phase, phi_hold;
   logic                      ag_last;
   logic signed [DATA_W-1:0]  sin_r, re_r, im_r;
   logic                      last_r, done_r;

   twiddle_addr_gen #(
      .LOG2N   (LOG2N),
      .PHASE_W (PHASE_W)
   ) u_addr (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load),
      .adv   (adv),
      .clr   (flush),
      .stage (stage),
      .phase (phase),
      .last  (ag_last)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= nstate;
   end

   always_comb begin
      nstate = state;
      load   = 1'b0;
      adv    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               load   = 1'b1;
               nstate = ST_SIN;
            end
         end
         ST_SIN:  nstate = ST_COS;
         ST_COS:  nstate = ST_VALID;
         ST_VALID: begin
            if (tw_ready) begin
               adv    = 1'b1;
               nstate = last_r ? ST_IDLE : ST_SIN;
            end
         end
         default: nstate = ST_IDLE;
      endcase
      if (flush) begin
         nstate = ST_IDLE;
         load   = 1'b0;
         adv    = 1'b0;
      end
   end

   // LUT phase is only driven fresh in SIN/COS; elsewhere the last value is
   // replayed so the LUT input does not toggle while idle or stalled.
   always_comb begin
      case (state)
         ST_SIN:  lut_phi = phase;
         ST_COS:  lut_phi = phase + PHASE_W'(QUARTER);
         default: lut_phi = phi_hold;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phi_hold <= '0;
         sin_r    <= '0;
         re_r     <= '0;
         im_r     <= '0;
         last_r   <= 1'b0;
         done_r   <= 1'b0;
      end else begin
         phi_hold <= lut_phi;
         done_r   <= (state == ST_VALID) && tw_ready && last_r && !flush;
         if (state == ST_SIN && !flush) sin_r <= lut_data;
         if (state == ST_COS && !flush) begin
            re_r   <= lut_data;
            im_r   <= DATA_W'(sat_neg(32'(sin_r), DATA_W));
            last_r <= ag_last;
         end
      end
   end

   assign tw_valid = (state == ST_VALID);
   assign tw_re    = re_r;
   assign tw_im    = im_r;
   assign tw_last  = tw_valid & last_r;
   assign busy     = (state != ST_IDLE);
   assign done     = done_r;

endmodule

// File: tb/tb_twiddle_seq.sv
// Scoreboard bench for twiddle_seq: two instances (LOG2N=8 and LOG2N=4)
// share a clock; expected twiddles are generated from the nested k/g loop
// description and a sine LUT model, and popped by an independent monitor.
module tb_twiddle_seq;

   localparam real PI = 3.14159265358979323846;

   typedef struct {
      int re;
      int im;
      bit last;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start_s [2];
   logic        flush_s [2];
   logic        rdy_s   [2];
   logic [2:0]  stage_s [2];
   logic [7:0]  phi_s   [2];
   logic [15:0] lut_s   [2];
   logic        valid_s [2];
   logic        last_s  [2];
   logic        busy_s  [2];
   logic        done_s  [2];
   logic [15:0] re_s    [2];
   logic [15:0] im_s    [2];

   bit   force_min = 1'b0;
   bit   rnd_ready = 1'b0;
   int   vectors = 0, miscompares = 0;
   int   cyc = 0, t0 = 0, hs8 = 0;
   exp_t q8[$], q4[$];

   always #5 clk = ~clk;

   function automatic int lut(int phi);
      real r;
      r = 32767.0 * $sin(2.0 * PI * real'(phi) / 256.0);
      return $rtoi(r >= 0.0 ? r + 0.5 : r - 0.5);
   endfunction

   function automatic int lut_d(int d, int phi);
      if (d == 1 && force_min) return -32768;
      return lut(phi);
   endfunction

   assign lut_s[0] = 16'(lut(int'(phi_s[0])));
   assign lut_s[1] = 16'(lut_d(1, int'(phi_s[1])));

   twiddle_seq #(.LOG2N(8), .PHASE_W(8), .DATA_W(16)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start_s[0]), .stage(stage_s[0]),
      .flush(flush_s[0]), .lut_phi(phi_s[0]), .lut_data(lut_s[0]),
      .tw_valid(valid_s[0]), .tw_ready(rdy_s[0]), .tw_re(re_s[0]),
      .tw_im(im_s[0]), .tw_last(last_s[0]), .busy(busy_s[0]), .done(done_s[0])
   );

   twiddle_seq #(.LOG2N(4), .PHASE_W(8), .DATA_W(16)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(start_s[1]), .stage(stage_s[1]),
      .flush(flush_s[1]), .lut_phi(phi_s[1]), .lut_data(lut_s[1]),
      .tw_valid(valid_s[1]), .tw_ready(rdy_s[1]), .tw_re(re_s[1]),
      .tw_im(im_s[1]), .tw_last(last_s[1]), .busy(busy_s[1]), .done(done_s[1])
   );

   task automatic chk(string name, int act, int exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Monitor: done pulse check, stall stability, scoreboard pop on handshake.
   initial begin
      bit   pend  [2];
      bit   stall [2];
      int   h_re [2], h_im [2], h_last [2], h_phi [2];
      exp_t e;
      bit   have;
      pend  = '{0, 0};
      stall = '{0, 0};
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            pend  = '{0, 0};
            stall = '{0, 0};
         end else begin
            for (int i = 0; i < 2; i++) begin
               chk("done_pulse", int'(done_s[i]), int'(pend[i]));
               pend[i] = 1'b0;
               if (stall[i]) begin
                  chk("hold_valid", int'(valid_s[i]), 1);
                  chk("hold_re",    int'($signed(re_s[i])), h_re[i]);
                  chk("hold_im",    int'($signed(im_s[i])), h_im[i]);
                  chk("hold_last",  int'(last_s[i]), h_last[i]);
                  chk("hold_phi",   int'(phi_s[i]), h_phi[i]);
               end
               stall[i] = valid_s[i] && !rdy_s[i];
               h_re[i]   = int'($signed(re_s[i]));
               h_im[i]   = int'($signed(im_s[i]));
               h_last[i] = int'(last_s[i]);
               h_phi[i]  = int'(phi_s[i]);
               if (valid_s[i] && rdy_s[i]) begin
                  if (i == 0) hs8++;
                  have = (i == 0) ? (q8.size() > 0) : (q4.size() > 0);
                  chk("sb_underflow", int'(have), 1);
                  if (have) begin
                     e = (i == 0) ? q8.pop_front() : q4.pop_front();
                     chk(i == 0 ? "re8" : "re4", int'($signed(re_s[i])), e.re);
                     chk(i == 0 ? "im8" : "im4", int'($signed(im_s[i])), e.im);
                     chk(i == 0 ? "last8" : "last4", int'(last_s[i]), int'(e.last));
                     pend[i] = e.last;
                  end
               end
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      if (rnd_ready) rdy_s[0] = ($urandom_range(0, 3) != 0);
   endtask

   // Reference: N/2 twiddles, outer g over 2^s groups, inner k, phase k*step.
   task automatic build(int d, int st);
      int   l, s, n, stp, kn, gn, ph;
      exp_t e;
      l   = (d == 0) ? 8 : 4;
      s   = (st >= l) ? l - 1 : st;
      n   = 1 << l;
      stp = 1 << (s + 8 - l);
      kn  = n >> (s + 1);
      gn  = 1 << s;
      for (int g = 0; g < gn; g++)
         for (int k = 0; k < kn; k++) begin
            ph     = (k * stp) % 256;
            e.re   = lut_d(d, (ph + 64) % 256);
            e.im   = -lut_d(d, ph);
            if (e.im > 32767) e.im = 32767;
            e.last = (g == gn - 1) && (k == kn - 1);
            if (d == 0) q8.push_back(e);
            else        q4.push_back(e);
         end
   endtask

   task automatic start_frame(int d, int st);
      build(d, st);
      stage_s[d] = 3'(st);
      start_s[d] = 1'b1;
      t0 = cyc;
      step();
      start_s[d] = 1'b0;
   endtask

   task automatic wait_done(int d, int limit, bit noise, output int lat);
      bit seen;
      seen = 1'b0;
      lat  = -1;
      for (int c = 0; c < limit && !seen; c++) begin
         step();
         if (done_s[d]) begin
            seen = 1'b1;
            lat  = cyc - t0;
         end else begin
            // stray start while busy must be ignored
            start_s[d] = noise && busy_s[d] && ($urandom_range(0, 15) == 0);
         end
      end
      start_s[d] = 1'b0;
      chk("done_seen", int'(seen), 1);
      chk("sb_drained", (d == 0) ? q8.size() : q4.size(), 0);
   endtask

   task automatic chk_zero(int d);
      chk("z_phi",   int'(phi_s[d]), 0);
      chk("z_re",    int'(re_s[d]), 0);
      chk("z_im",    int'(im_s[d]), 0);
      chk("z_valid", int'(valid_s[d]), 0);
      chk("z_last",  int'(last_s[d]), 0);
      chk("z_busy",  int'(busy_s[d]), 0);
      chk("z_done",  int'(done_s[d]), 0);
   endtask

   initial begin
      int  lat;
      int  base;
      bit  seen;
      for (int i = 0; i < 2; i++) begin
         start_s[i] = 1'b0;
         flush_s[i] = 1'b0;
         rdy_s[i]   = 1'b1;
         stage_s[i] = 3'd0;
      end
      #12;
      chk_zero(0);
      chk_zero(1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step();

      // stage 0: 128 twiddles, 3 cycles each
      start_frame(0, 0);
      wait_done(0, 1000, 1'b0, lat);
      chk("latency_s0", lat, 385);
      // start in the same cycle as done is accepted
      start_frame(0, 1);
      wait_done(0, 1000, 1'b0, lat);
      start_frame(0, 7);
      wait_done(0, 1000, 1'b0, lat);

      // random stages with random backpressure and stray starts
      rnd_ready = 1'b1;
      repeat (4) begin
         start_frame(0, int'($urandom_range(0, 7)));
         wait_done(0, 3000, 1'b1, lat);
      end
      rnd_ready = 1'b0;
      rdy_s[0]  = 1'b1;

      // 10-cycle stall on the 3rd twiddle
      base = hs8;
      start_frame(0, 0);
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
         if (hs8 - base == 2 && valid_s[0]) seen = 1'b1;
         else step();
      end
      chk("bp_reach", int'(seen), 1);
      rdy_s[0] = 1'b0;
      repeat (10) step();
      rdy_s[0] = 1'b1;
      wait_done(0, 1000, 1'b0, lat);

      // flush during COS of the 5th twiddle
      start_frame(0, 0);
      repeat (13) step();
      chk("flush_in_cos5", int'(phi_s[0]), 68);
      flush_s[0] = 1'b1;
      step();
      flush_s[0] = 1'b0;
      chk("flush_busy",  int'(busy_s[0]), 0);
      chk("flush_valid", int'(valid_s[0]), 0);
      chk("flush_done",  int'(done_s[0]), 0);
      chk("flush_popped", q8.size(), 124);
      q8.delete();
      repeat (5) step();
      chk("flush_idle", int'(busy_s[0]), 0);
      start_frame(0, 0);
      wait_done(0, 1000, 1'b0, lat);

      // async reset while stalled in VALID
      rdy_s[0] = 1'b0;
      start_frame(0, 2);
      seen = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
         step();
         seen = valid_s[0];
      end
      chk("rst_reach_valid", int'(seen), 1);
      rst_n = 1'b0;
      #1;
      chk_zero(0);
      q8.delete();
      step();
      rst_n    = 1'b1;
      rdy_s[0] = 1'b1;
      step();
      start_frame(0, 0);
      wait_done(0, 1000, 1'b0, lat);

      // LOG2N=4: stage 6 clamps to 3 -> 8 pairs
      start_frame(1, 6);
      wait_done(1, 200, 1'b0, lat);
      chk("latency_clamp", lat, 25);
      // most negative LUT code saturates on negation
      force_min = 1'b1;
      start_frame(1, 3);
      wait_done(1, 200, 1'b0, lat);
      force_min = 1'b0;

      repeat (3) step();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/twiddle_seq.md
Name: twiddle_seq

Overview:
- Sequences the shared quarter-wave sine LUT wrapper (8-bit phase in, signed 16-bit value out, combinational) for one DIF FFT butterfly stage.
- Per frame, generates the DIF twiddle order, time-shares the single LUT between the sine and cosine lookups, and registers each result.
- Presents W = cos − j·sin to the butterfly unit over a valid/ready handshake.
- Sits between the stage controller (start/stage) and the BFU twiddle multiplier.

Parameters:
- LOG2N, 8, log2 of FFT size N; legal range 2..8.
- PHASE_W, 8, LUT phase width; 256 steps per full circle, fixed by the LUT wrapper.
- DATA_W, 16, LUT output and twiddle width.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle frame start; sampled only in IDLE.
- stage  in  3  DIF stage index, sampled with start.
- flush  in  1  synchronous abort to IDLE; no done pulse.
- lut_phi  out  PHASE_W  phase driven to the sine LUT wrapper.
- lut_data  in  DATA_W  signed LUT result; combinational from lut_phi.
- tw_valid  out  1  twiddle pair valid.
- tw_ready  in  1  consumer accepts the pair.
- tw_re  out  DATA_W  signed cos term.
- tw_im  out  DATA_W  signed −sin term.
- tw_last  out  1  marks the final twiddle of the frame; qualified by tw_valid.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse after the last handshake.

Behaviour:
- Reset (async, rst_n low): state IDLE. All outputs 0: lut_phi, tw_re, tw_im, tw_valid, tw_last, busy, done. Counters 0.
- Stage clamp: stage ≥ LOG2N is treated as LOG2N−1.
- Phase step: step = 2^(s + 8 − LOG2N).
- Counters:
  - k runs 0..(N>>(s+1))−1 (inner loop).
  - g runs 0..2^s−1 (outer loop).
  - phase = (k·step) mod 256.
  - N/2 twiddles per frame.
- FSM states: IDLE, SIN, COS, VALID.
  - IDLE: on start, latch s, clear k/g, go to SIN. start is ignored in all other states.
  - SIN: lut_phi = phase. At the clock edge, register sin_r ← lut_data. Go to COS.
  - COS: lut_phi = (phase + 64) mod 256. At the clock edge:
    - tw_re ← lut_data.
    - tw_im ← −sin_r, saturated: −32768 maps to +32767.
    - tw_last ← (k and g both at their maximum).
    - Go to VALID.
  - VALID: tw_valid = 1; tw_re, tw_im and tw_last are held stable until the handshake.
    - On tw_ready: advance k; when k wraps, advance g.
    - If tw_last: go to IDLE and pulse done for one cycle.
    - Otherwise: go to SIN.
- lut_phi holds its last value in IDLE and VALID.
- Latency: start sampled at edge t gives tw_valid high from edge t+3.
- Throughput: one twiddle per 3 cycles with tw_ready tied high.
- Backpressure: no limit on stall length in VALID; nothing changes while tw_ready is low.
- flush: has priority over start and tw_ready in every state.
  - Next state is IDLE; tw_valid cleared, counters cleared.
  - No done pulse; tw_re/tw_im are not cleared.
- Async reset mid-frame: immediate return to the reset state. The next start begins a fresh frame.
- done and start in the same cycle: start is accepted, because the state is already IDLE in that cycle.

Decomposition:
- Shared package twiddle_pkg:
  - State encoding (IDLE/SIN/COS/VALID).
  - Constant QUARTER = 64 (phase offset for cosine).
  - Constant PHASE_FULL = 256.
  - Saturating negate function.
- One sub-module, twiddle_addr_gen:
  - Contains the k/g counters, step shift, phase and last flag.
  - Controlled by load/advance inputs from the FSM.

Test Plan:
- Bench LUT model returns round(32767·sin(2π·phi/256)).
- LOG2N=8, stage 0, tw_ready=1:
  - 128 twiddles with phases 0..127.
  - First pair (32767, 0); 65th pair (phase 64) is (0, −32767).
  - tw_last only on the 128th; done one cycle after it.
  - Exactly 384 cycles from start to done−1.
- LOG2N=8, stage 1:
  - Phase sequence 0,2,…,126 appears twice.
  - tw_last set only at the end of the second pass.
- LOG2N=8, stage 7:
  - 128 pairs, all (32767, 0); tw_last on the final pair.
- Backpressure:
  - tw_ready low for 10 cycles on the 3rd twiddle: pair held stable, no phase advance.
  - Sequence resumes at phase 3 (stage 0).
- Abort/reset:
  - flush during COS of the 5th twiddle: IDLE next cycle, no done, busy=0.
  - rst_n pulsed low mid-VALID: all outputs 0 immediately.
  - A new start produces phase 0 first.
- Clamp and saturation:
  - LOG2N=4, stage 6: behaves as stage 3 (step 128, 8 pairs of (32767, 0)).
  - LUT model forced to −32768 yields tw_im = +32767.
